ads868x_scan_ctrl: RTL and testbench

ADS868X_SCAN_CTRL -- requirements
Module: ads868x_scan_ctrl

---
 rtl/ads868x_scan_ctrl_if.sv | 30 +++
 rtl/ads868x_scan_ctrl.sv | 164 ++++++++++++++++
 tb/tb_ads868x_scan_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ads868x_scan_ctrl_if.sv
// ADC SPI lines and the sample stream of the ADS868x scan controller.
// The master side belongs to the controller; the slave side to the ADC and the downstream consumer.
interface ads868x_scan_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
);
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W-1:0] m_tdata;
  logic [SEL_W-1:0]  m_tuser;
  logic              m_tlast;

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi,
    input  spi_miso,
    output m_tvalid, m_tdata, m_tuser, m_tlast,
    input  m_tready
  );

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi,
    output spi_miso,
    input  m_tvalid, m_tdata, m_tuser, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/ads868x_scan_ctrl.sv
// Scans the enabled analog-mux channels and, for each one, settles the mux, runs one ADS868x
// conversion, reads 32 SPI bits and emits a tagged sample on the stream.
module ads868x_scan_ctrl #(
  parameter int NUM_CH     = 8,
  parameter int SEL_W      = 3,
  parameter int DATA_W     = 16,
  parameter int SCLK_DIV   = 4,
  parameter int SETTLE_CYC = 100,
  parameter int CONV_CYC   = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic              overrun,
  output logic [SEL_W-1:0]  ch_sel,
  ads868x_scan_ctrl_if.master bus
);

  // One shared counter covers SETTLE and CONV; XFER uses phase/bit counters instead.
  localparam int CNT_MAX = (SETTLE_CYC > CONV_CYC + 2) ? SETTLE_CYC : CONV_CYC + 2;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int PH_W    = $clog2(SCLK_DIV);
  localparam int HALF    = SCLK_DIV / 2;

  typedef enum logic [2:0] {IDLE, SETTLE, CONV, XFER, OUT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [4:0]        bit_q, bit_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_d;
  logic [SEL_W-1:0]  first_sel, next_sel;
  logic              has_next;
  logic [DATA_W-1:0] sh_q;

  // Lowest set bit of the incoming mask, and the next set bit above the current channel.
  always_comb begin
    first_sel = '0;
    next_sel  = '0;
    has_next  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_sel = SEL_W'(i);
      if (mask_q[i] && (i > int'(ch_sel))) begin
        next_sel = SEL_W'(i);
        has_next = 1'b1;
      end
    end
  end

  function automatic logic cs_level(state_t s, logic [CNT_W-1:0] c);
    case (s)
      CONV:    return (c >= CNT_W'(2));
      XFER:    return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // NOTE: every combinational output gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    mask_d  = mask_q;
    sel_d   = ch_sel;
    case (state_q)
      IDLE: begin
        if (trig && (|ch_mask)) begin
          state_d = SETTLE;
          cnt_d   = '0;
          mask_d  = ch_mask;
          sel_d   = first_sel;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(CONV_CYC + 1)) begin
          state_d = XFER;
          ph_d    = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XFER: begin
        if (ph_q == PH_W'(SCLK_DIV - 1)) begin
          ph_d = '0;
          if (bit_q == 5'd31) state_d = OUT;
          else                bit_d   = bit_q + 1'b1;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      OUT: begin
        // Holding here under backpressure keeps the next conversion from starting.
        if (bus.m_tvalid && bus.m_tready) begin
          if (bus.m_tlast) begin
            state_d = IDLE;
          end else begin
            state_d = SETTLE;
            cnt_d   = '0;
            sel_d   = next_sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ph_q         <= '0;
      bit_q        <= '0;
      mask_q       <= '0;
      ch_sel       <= '0;
      sh_q         <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      bus.spi_cs_n <= 1'b1;
      bus.spi_sclk <= 1'b0;
      bus.m_tvalid <= 1'b0;
      bus.m_tdata  <= '0;
      bus.m_tlast  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ph_q         <= ph_d;
      bit_q        <= bit_d;
      mask_q       <= mask_d;
      ch_sel       <= sel_d;
      busy         <= (state_d != IDLE);
      overrun      <= trig && (state_q != IDLE);
      // SPI pins are registered from the next state so they change cleanly on the clock edge.
      bus.spi_cs_n <= cs_level(state_d, cnt_d);
      bus.spi_sclk <= (state_d == XFER) && (ph_d >= PH_W'(HALF));
      bus.m_tvalid <= (state_d == OUT);
      if (state_q == XFER && ph_q == PH_W'(HALF) && int'(bit_q) < DATA_W)
        sh_q <= {sh_q[DATA_W-2:0], bus.spi_miso};
      if (state_q == XFER && state_d == OUT) begin
        bus.m_tdata <= sh_q;
        bus.m_tlast <= !has_next;
      end
    end
  end

  assign bus.m_tuser  = ch_sel;
  assign bus.spi_mosi = 1'b0;

endmodule

// File: tb/tb_ads868x_scan_ctrl.sv
// Directed bench for ads868x_scan_ctrl: a 16-bit instance exercises scan, backpressure, overrun
// and reset; an 18-bit instance checks capture width. Each SPI slave shifts a fixed frame.
module tb_ads868x_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       trig_a, trig_b;
  logic [7:0] ch_mask_a, ch_mask_b;
  logic       busy_a, busy_b, overrun_a, overrun_b;
  logic [2:0] ch_sel_a, ch_sel_b;
  logic       tready_a;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  ads868x_scan_ctrl_if #(.DATA_W(16), .SEL_W(3)) bus_a ();
  ads868x_scan_ctrl_if #(.DATA_W(18), .SEL_W(3)) bus_b ();

  ads868x_scan_ctrl #(.NUM_CH(8), .SEL_W(3), .DATA_W(16), .SCLK_DIV(2),
                      .SETTLE_CYC(4), .CONV_CYC(8)) dut_a (
    .clk(clk), .rst(rst), .trig(trig_a), .ch_mask(ch_mask_a), .busy(busy_a),
    .overrun(overrun_a), .ch_sel(ch_sel_a), .bus(bus_a));

  ads868x_scan_ctrl #(.NUM_CH(8), .SEL_W(3), .DATA_W(18), .SCLK_DIV(2),
                      .SETTLE_CYC(4), .CONV_CYC(8)) dut_b (
    .clk(clk), .rst(rst), .trig(trig_b), .ch_mask(ch_mask_b), .busy(busy_b),
    .overrun(overrun_b), .ch_sel(ch_sel_b), .bus(bus_b));

  // Per-channel sample value so a wrong tag or a stale word shows up in the data.
  function automatic logic [15:0] exp_a(input logic [2:0] ch);
    return 16'hA5C3 ^ (16'(ch) * 16'h1111);
  endfunction

  // ADC model: bit k of the frame is presented after the k-th SCLK fall; CS high rewinds.
  logic [31:0] frame_a, frame_b;
  int          idx_a = 0, idx_b = 0;
  assign frame_a = {exp_a(ch_sel_a), 16'hFFFF};
  assign frame_b = {18'h2D5A7, 14'h3FFF};
  always @(negedge bus_a.spi_sclk or posedge bus_a.spi_cs_n)
    if (bus_a.spi_cs_n) idx_a <= 0; else idx_a <= idx_a + 1;
  always @(negedge bus_b.spi_sclk or posedge bus_b.spi_cs_n)
    if (bus_b.spi_cs_n) idx_b <= 0; else idx_b <= idx_b + 1;
  assign bus_a.spi_miso = (idx_a < 32) ? frame_a[31-idx_a] : 1'b0;
  assign bus_b.spi_miso = (idx_b < 32) ? frame_b[31-idx_b] : 1'b0;
  assign bus_a.m_tready = tready_a;
  assign bus_b.m_tready = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus_a.m_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  bit         ok;
  bit         stable;
  bit         quiet;
  logic [2:0] exp_ch [3] = '{3'd2, 3'd5, 3'd7};

  initial begin
    rst = 1'b1; trig_a = 1'b0; trig_b = 1'b0;
    ch_mask_a = '0; ch_mask_b = 8'h01; tready_a = 1'b0;
    // Reset value checks; trig during reset must also be ignored.
    tick();
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_overrun", overrun_a, 0);
    check("rst_cs_sclk_mosi", {bus_a.spi_cs_n, bus_a.spi_sclk, bus_a.spi_mosi}, 3'b100);
    check("rst_stream", {bus_a.m_tvalid, bus_a.m_tlast, bus_a.m_tuser, ch_sel_a}, 0);
    check("rst_tdata", bus_a.m_tdata, 0);
    rst = 1'b0;
    tick();
    check("rst_trig_ignored", busy_a, 0);

    // Single-channel frame timing: trig at cycle 0.
    ch_mask_a = 8'h01; trig_a = 1'b1;
    tick();                     // cycle 1
    trig_a = 1'b0;
    check("c1_busy", busy_a, 1);
    check("c1_cs_high", bus_a.spi_cs_n, 1);
    repeat (3) tick();          // cycle 4
    check("c4_cs_high", bus_a.spi_cs_n, 1);
    tick();                     // cycle 5
    check("c5_cs_low", bus_a.spi_cs_n, 0);
    tick();                     // cycle 6
    check("c6_cs_low", bus_a.spi_cs_n, 0);
    tick();                     // cycle 7
    check("c7_cs_high", bus_a.spi_cs_n, 1);
    repeat (7) tick();          // cycle 14
    check("c14_cs_high", bus_a.spi_cs_n, 1);
    tick();                     // cycle 15
    check("c15_xfer_start", {bus_a.spi_cs_n, bus_a.spi_sclk}, 2'b00);
    check("c15_mosi", bus_a.spi_mosi, 0);
    tick();                     // cycle 16
    check("c16_sclk_high", {bus_a.spi_cs_n, bus_a.spi_sclk}, 2'b01);
    repeat (62) tick();         // cycle 78
    check("c78_cs_low_no_valid", {bus_a.spi_cs_n, bus_a.m_tvalid}, 2'b00);
    tick();                     // cycle 79
    check("c79_valid_cs", {bus_a.m_tvalid, bus_a.spi_cs_n}, 2'b11);
    check("c79_tdata", bus_a.m_tdata, 16'hA5C3);
    check("c79_tuser_tlast", {bus_a.m_tuser, bus_a.m_tlast}, {3'd0, 1'b1});
    tready_a = 1'b1;
    tick();                     // cycle 80
    check("c80_done", {bus_a.m_tvalid, busy_a}, 2'b00);

    // Multi-channel scan with a mask change and a repeated trig mid-scan.
    ch_mask_a = 8'b1010_0100; trig_a = 1'b1;
    tick();
    trig_a = 1'b0; ch_mask_a = 8'hFF;
    check("scan_first_sel", ch_sel_a, 2);
    tick();
    trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    check("overrun_pulse", overrun_a, 1);
    tick();
    check("overrun_one_cycle", overrun_a, 0);
    for (int k = 0; k < 3; k++) begin
      wait_valid_a(ok);
      check("scan_timeout", ok, 1);
      check("scan_tuser", bus_a.m_tuser, exp_ch[k]);
      check("scan_tdata", bus_a.m_tdata, exp_a(exp_ch[k]));
      check("scan_tlast", bus_a.m_tlast, (k == 2) ? 1 : 0);
      tick();
      check("scan_busy_after_hs", busy_a, (k == 2) ? 0 : 1);
    end

    // Empty mask trig in IDLE does nothing.
    ch_mask_a = 8'h00; trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    check("zero_mask_idle", {busy_a, overrun_a}, 2'b00);

    // Backpressure: first sample held 50 cycles with tready low.
    tready_a = 1'b0; ch_mask_a = 8'b0001_0010; trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    wait_valid_a(ok);
    check("bp_timeout", ok, 1);
    check("bp_tuser", bus_a.m_tuser, 1);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (!(bus_a.m_tvalid === 1'b1 && bus_a.m_tdata === exp_a(3'd1) && bus_a.m_tuser === 3'd1 &&
            bus_a.m_tlast === 1'b0 && bus_a.spi_cs_n === 1'b1 && bus_a.spi_sclk === 1'b0))
        stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    tready_a = 1'b1;
    tick();
    check("bp_released", bus_a.m_tvalid, 0);
    wait_valid_a(ok);
    check("bp2_timeout", ok, 1);
    check("bp2_sample", {bus_a.m_tuser, bus_a.m_tlast}, {3'd4, 1'b1});
    check("bp2_tdata", bus_a.m_tdata, exp_a(3'd4));
    tick();

    // Reset in the middle of XFER with a simultaneous trig.
    ch_mask_a = 8'h08; trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    repeat (30) tick();
    check("mid_xfer_cs", {bus_a.spi_cs_n, ch_sel_a}, {1'b0, 3'd3});
    rst = 1'b1; trig_a = 1'b1;
    tick();
    rst = 1'b0; trig_a = 1'b0;
    check("abort_ctrl", {busy_a, overrun_a, ch_sel_a}, 0);
    check("abort_spi", {bus_a.spi_cs_n, bus_a.spi_sclk, bus_a.spi_mosi}, 3'b100);
    check("abort_stream", {bus_a.m_tvalid, bus_a.m_tlast, bus_a.m_tuser}, 0);
    check("abort_tdata", bus_a.m_tdata, 0);
    quiet = 1'b1;
    repeat (120) begin
      tick();
      if (bus_a.m_tvalid !== 1'b0 || busy_a !== 1'b0) quiet = 1'b0;
    end
    check("abort_no_sample", quiet, 1);
    ch_mask_a = 8'h01; trig_a = 1'b1;
    tick();
    trig_a = 1'b0;
    wait_valid_a(ok);
    check("post_rst_timeout", ok, 1);
    check("post_rst_tdata", bus_a.m_tdata, 16'hA5C3);
    check("post_rst_tag", {bus_a.m_tuser, bus_a.m_tlast}, {3'd0, 1'b1});
    tick();

    // 18-bit capture: only the first 18 MISO bits land in the sample.
    trig_b = 1'b1;
    tick();
    trig_b = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus_b.m_tvalid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("w18_timeout", ok, 1);
    check("w18_tdata", bus_b.m_tdata, 18'h2D5A7);
    check("w18_tag", {bus_b.m_tuser, bus_b.m_tlast}, {3'd0, 1'b1});
    tick();
    check("w18_done", {bus_b.m_tvalid, busy_b}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
